// File: rtl/lab4_net_ring_out_arbiter.sv
// -----------------------------------------------------------------------------
// lab4_net_ring_out_arbiter
//
// Per-output-port scheduler for a ring router. Three inputs share one output
// channel: 0 = west ring, 1 = terminal injection, 2 = east ring.
//   - Round-robin priority starting at r_ptr, searched ptr, ptr+1, ptr+2 (mod 3).
//   - Arbitration is combinational: an input valid in cycle N can transfer in N.
//   - A grant offered while the output is stalled is held (HOLD) until it
//     transfers or the requester withdraws.
//   - Bubble flow control: terminal injection (input 1) may only win when the
//     downstream queue has at least p_bubble_min free entries. Ring traffic
//     therefore always has a slot left, so ring queues cannot deadlock.
//
// Ports
//   clk           clock, all state updates on posedge
//   reset         asynchronous, active-low reset
//   in_val[2:0]   per-input message valid
//   in_rdy[2:0]   per-input ready (grant AND out_rdy), one-hot or zero
//   out_val       output channel valid
//   out_rdy       output channel ready (downstream enq_rdy)
//   grant_idx     output mux select 0..2, 0 when nothing is granted
//   free_entries  downstream queue free-slot count
// -----------------------------------------------------------------------------
module lab4_net_ring_out_arbiter #(
  parameter int p_free_nbits = 3,
  parameter bit p_bubble_en  = 1'b1,
  parameter int p_bubble_min = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              in_val,
  output logic [2:0]              in_rdy,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [1:0]              grant_idx,
  input  logic [p_free_nbits-1:0] free_entries
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [p_free_nbits:0] lp_bubble_min = p_bubble_min[p_free_nbits:0];

  // Successor in the 0..2 ring; the illegal code 3 behaves as 0.
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    case (v)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      2'd2:    return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_held;

  state_t     w_state_nxt;
  logic [1:0] w_ptr_nxt;
  logic [1:0] w_held_nxt;

  logic [1:0] w_ptr;
  logic [1:0] w_held;
  logic       w_bubble_ok;
  logic [2:0] w_elig;
  logic [1:0] w_order0;
  logic [1:0] w_order1;
  logic [1:0] w_order2;
  logic       w_found;
  logic [1:0] w_winner;

  // Map the unreachable code 3 onto 0 so a corrupted register self-heals.
  assign w_ptr  = (r_ptr  == 2'd3) ? 2'd0 : r_ptr;
  assign w_held = (r_held == 2'd3) ? 2'd0 : r_held;

  assign w_bubble_ok = ({1'b0, free_entries} >= lp_bubble_min);

  assign w_elig[0] = in_val[0];
  assign w_elig[1] = in_val[1] & (~p_bubble_en | w_bubble_ok);
  assign w_elig[2] = in_val[2];

  assign w_order0 = w_ptr;
  assign w_order1 = inc_mod3(w_ptr);
  assign w_order2 = inc_mod3(w_order1);

  // First eligible input in priority order.
  always_comb begin
    w_found  = 1'b1;
    w_winner = 2'd0;
    if (w_elig[w_order0]) begin
      w_winner = w_order0;
    end else if (w_elig[w_order1]) begin
      w_winner = w_order1;
    end else if (w_elig[w_order2]) begin
      w_winner = w_order2;
    end else begin
      w_found = 1'b0;
    end
  end

  // Next-state and output logic.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = w_ptr;
    w_held_nxt  = w_held;
    out_val     = 1'b0;
    in_rdy      = 3'b000;
    grant_idx   = 2'd0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          out_val           = 1'b1;
          grant_idx         = w_winner;
          in_rdy[w_winner]  = out_rdy;
          if (out_rdy) begin
            w_ptr_nxt = inc_mod3(w_winner);
          end else begin
            w_state_nxt = S_HOLD;
            w_held_nxt  = w_winner;
          end
        end
      end

      S_HOLD: begin
        // The grant was legal when issued, so priority and the bubble rule
        // are not re-evaluated here.
        grant_idx = w_held;
        out_val   = in_val[w_held];
        if (in_val[w_held]) begin
          in_rdy[w_held] = out_rdy;
          if (out_rdy) begin
            w_ptr_nxt   = inc_mod3(w_held);
            w_state_nxt = S_IDLE;
          end
        end else begin
          // Requester withdrew: drop the hold without advancing priority.
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are quiet for as long as reset is held, not just at the edge.
    if (!reset) begin
      out_val   = 1'b0;
      in_rdy    = 3'b000;
      grant_idx = 2'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and clears all state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_held  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_held  <= w_held_nxt;
    end
  end

endmodule

// File: tb/tb_lab4_net_ring_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lab4_net_ring_out_arbiter
//
// Directed bench for the ring output arbiter (default parameters: bubble rule
// on, minimum 2 free entries). Inputs change 2 time units after a rising edge
// and outputs are compared 1 time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_lab4_net_ring_out_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] in_val;
  logic [2:0] in_rdy;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] grant_idx;
  logic [2:0] free_entries;

  int n_checks = 0;
  int n_errors = 0;

  lab4_net_ring_out_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .grant_idx    (grant_idx),
    .free_entries (free_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot plus the in_rdy invariants.
  task automatic check_out(input string tag, input logic ov, input logic [1:0] gi,
                           input logic [2:0] rdy);
    check({tag, ".out_val"},   {7'd0, out_val},   {7'd0, ov});
    check({tag, ".grant_idx"}, {6'd0, grant_idx}, {6'd0, gi});
    check({tag, ".in_rdy"},    {5'd0, in_rdy},    {5'd0, rdy});
    check({tag, ".onehot"},    {7'd0, $onehot0(in_rdy)}, 8'd1);
    if (in_rdy != 3'b000)
      check({tag, ".rdy_implies_val"}, {6'd0, out_val, out_rdy}, 8'd3);
  endtask

  // Advance one cycle, then leave room to drive inputs.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    in_val       = 3'b111;
    out_rdy      = 1'b1;
    free_entries = 3'd7;

    // 1. Reset held low with all inputs requesting: nothing is granted.
    #2;
    check_out("t1_reset", 1'b0, 2'd0, 3'b000);
    tick();
    check_out("t1_reset_edge", 1'b0, 2'd0, 3'b000);

    // Release mid-cycle; round robin from ptr=0: 0,1,2,0.
    reset = 1'b1;
    settle();
    check_out("t1_g0", 1'b1, 2'd0, 3'b001);
    tick(); settle();
    check_out("t1_g1", 1'b1, 2'd1, 3'b010);
    tick(); settle();
    check_out("t1_g2", 1'b1, 2'd2, 3'b100);
    tick(); settle();
    check_out("t1_g0b", 1'b1, 2'd0, 3'b001);
    tick();

    // 2. ptr=1, inputs 0 and 2 requesting: 2, 0, 2.
    in_val = 3'b101;
    settle();
    check_out("t2_g2", 1'b1, 2'd2, 3'b100);
    tick(); settle();
    check_out("t2_g0", 1'b1, 2'd0, 3'b001);
    tick(); settle();
    check_out("t2_g2b", 1'b1, 2'd2, 3'b100);
    tick();

    // 3. ptr=0. Injection only, one free slot: blocked by the bubble rule.
    in_val       = 3'b010;
    free_entries = 3'd1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_out($sformatf("t3_bubble%0d", c), 1'b0, 2'd0, 3'b000);
      tick();
    end
    free_entries = 3'd2;
    settle();
    check_out("t3_free2", 1'b1, 2'd1, 3'b010);
    tick();

    // 4. ptr=2. Input 0 wins while stalled, then the grant is held while
    //    input 2 (top priority) toggles.
    in_val  = 3'b001;
    out_rdy = 1'b0;
    settle();
    check_out("t4_offer", 1'b1, 2'd0, 3'b000);
    tick();
    for (int c = 0; c < 3; c++) begin
      in_val = (c % 2 == 0) ? 3'b101 : 3'b001;
      settle();
      check_out($sformatf("t4_hold%0d", c), 1'b1, 2'd0, 3'b000);
      tick();
    end
    in_val  = 3'b101;
    out_rdy = 1'b1;
    settle();
    check_out("t4_release", 1'b1, 2'd0, 3'b001);
    tick();
    // ptr=1 now: input 1 is next.
    in_val = 3'b111;
    settle();
    check_out("t4_next", 1'b1, 2'd1, 3'b010);
    tick();

    // 5. ptr=2. Drain input 2 so ptr returns to 0, then hold input 1.
    in_val = 3'b100;
    settle();
    check_out("t5_drain2", 1'b1, 2'd2, 3'b100);
    tick();
    in_val       = 3'b010;
    free_entries = 3'd2;
    out_rdy      = 1'b0;
    settle();
    check_out("t5_offer1", 1'b1, 2'd1, 3'b000);
    tick();
    // In HOLD: no free entries and input 0 requesting do not break the grant.
    in_val       = 3'b011;
    free_entries = 3'd0;
    settle();
    check_out("t5_hold_nofree", 1'b1, 2'd1, 3'b000);
    tick();
    settle();
    check_out("t5_hold_again", 1'b1, 2'd1, 3'b000);
    // Withdraw input 1: out_val drops while still in HOLD.
    in_val = 3'b001;
    settle();
    check("t5_withdraw.out_val", {7'd0, out_val}, 8'd0);
    check("t5_withdraw.in_rdy",  {5'd0, in_rdy},  8'd0);
    tick();
    // Back in IDLE with ptr still 0: input 1 beats input 2.
    in_val       = 3'b110;
    free_entries = 3'd7;
    settle();
    check_out("t5_ptr_kept", 1'b1, 2'd1, 3'b000);
    out_rdy = 1'b1;
    settle();
    check_out("t5_xfer1", 1'b1, 2'd1, 3'b010);
    tick();

    // 6. ptr=2. Hold input 2, then assert reset mid-cycle.
    in_val  = 3'b100;
    out_rdy = 1'b0;
    settle();
    check_out("t6_offer2", 1'b1, 2'd2, 3'b000);
    tick();
    in_val  = 3'b111;
    settle();
    check_out("t6_hold2", 1'b1, 2'd2, 3'b000);
    #1;
    reset = 1'b0;
    #1;
    check_out("t6_async", 1'b0, 2'd0, 3'b000);
    tick();
    reset   = 1'b1;
    out_rdy = 1'b1;
    settle();
    check_out("t6_after", 1'b1, 2'd0, 3'b001);
    tick(); settle();
    check_out("t6_after_next", 1'b1, 2'd1, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
